pulse_event_detect: RTL and testbench

//  Multi-channel event detector for asynchronous single-bit inputs on one clock.
//  Per channel: synchroniser (depth set by parameter), programmable glitch

---
 rtl/pulse_event_pkg.sv | 29 ++
 rtl/pulse_event_chan.sv | 83 ++++++++
 rtl/pulse_event_detect.sv | 70 +++++++
 tb/tb_pulse_event_detect.sv | 207 ++++++++++++++++++++
 4 files changed

// File: rtl/pulse_event_pkg.sv
// -----------------------------------------------------------------------------
// pulse_event_pkg
//   Shared definitions for the pulse_event_detect block.
//   - edge_mode_e : per-channel edge-select encoding
//   - edge_enabled: decides whether a committed transition of the given
//                   direction should raise an event pulse under a mode
// -----------------------------------------------------------------------------
package pulse_event_pkg;

  typedef enum logic [1:0] {
    MODE_OFF  = 2'b00,
    MODE_RISE = 2'b01,
    MODE_FALL = 2'b10,
    MODE_BOTH = 2'b11
  } edge_mode_e;

  // rising = 1 when the filtered level has just gone 0 -> 1.
  function automatic logic edge_enabled(input logic [1:0] mode, input logic rising);
    logic en;
    case (edge_mode_e'(mode))
      MODE_RISE: en = rising;
      MODE_FALL: en = !rising;
      MODE_BOTH: en = 1'b1;
      default:   en = 1'b0;
    endcase
    return en;
  endfunction

endpackage

// File: rtl/pulse_event_chan.sv
// -----------------------------------------------------------------------------
// pulse_event_chan
//   One channel of the event detector: synchroniser chain, glitch filter with
//   a programmable length, edge decode and a registered one-cycle pulse.
//
// Ports
//   clk        : clock, rising edge
//   rst        : asynchronous reset, active-high
//   async_i    : asynchronous input for this channel
//   mode_i     : edge select (off / rise / fall / both)
//   filt_len_i : filter length F; a change must persist for F+1 samples
//   pulse_o    : registered one-cycle event pulse
//   evt_o      : next-state of pulse_o, lets the parent set sticky status on
//                the same edge the pulse is registered
// -----------------------------------------------------------------------------
module pulse_event_chan
  import pulse_event_pkg::*;
#(
  parameter int   SYNC_STAGES = 2,
  parameter int   FILT_W      = 4,
  parameter logic RESET_LVL   = 1'b0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              async_i,
  input  logic [1:0]        mode_i,
  input  logic [FILT_W-1:0] filt_len_i,
  output logic              pulse_o,
  output logic              evt_o
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   sync_s;
  logic                   flt_q, flt_d;
  logic [FILT_W-1:0]      cnt_q, cnt_d;
  logic                   pulse_q, pulse_d;

  // Synchroniser: bit 0 samples the pin, the top bit is the usable level.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_q <= {SYNC_STAGES{RESET_LVL}};
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], async_i};
    end
  end

  assign sync_s = sync_q[SYNC_STAGES-1];

  // Filter: cnt counts consecutive samples disagreeing with the committed
  // level. The >= compare (rather than ==) lets a filter length lowered below
  // the current count commit on the next disagreeing sample, and keeps cnt
  // from ever passing filt_len, so it cannot wrap.
  always_comb begin
    flt_d   = flt_q;
    cnt_d   = cnt_q;
    pulse_d = 1'b0;
    if (sync_s == flt_q) begin
      cnt_d = '0;
    end else if (cnt_q >= filt_len_i) begin
      flt_d   = sync_s;
      cnt_d   = '0;
      pulse_d = edge_enabled(mode_i, sync_s);
    end else begin
      cnt_d = cnt_q + FILT_W'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      flt_q   <= RESET_LVL;
      cnt_q   <= '0;
      pulse_q <= 1'b0;
    end else begin
      flt_q   <= flt_d;
      cnt_q   <= cnt_d;
      pulse_q <= pulse_d;
    end
  end

  assign pulse_o = pulse_q;
  assign evt_o   = pulse_d;

endmodule

// File: rtl/pulse_event_detect.sv
// -----------------------------------------------------------------------------
// pulse_event_detect
//   Multi-channel event detector for asynchronous single-bit inputs. Each
//   channel is synchronised, glitch filtered and edge decoded into a one-cycle
//   pulse; events are also latched in write-1-to-clear sticky status bits.
//
// Ports
//   clk       : clock, rising edge
//   rst       : asynchronous reset, active-high
//   async_in  : asynchronous inputs, one per channel
//   mode      : per-channel edge select, channel i at [2i+1:2i]
//   filt_len  : shared filter length F (quasi-static)
//   clr       : write-1-to-clear for sticky, per channel
//   pulse_out : one-cycle event pulse per channel (registered)
//   sticky    : latched event status per channel
//   any_event : OR of sticky
// -----------------------------------------------------------------------------
module pulse_event_detect
  import pulse_event_pkg::*;
#(
  parameter int   CH          = 4,
  parameter int   SYNC_STAGES = 2,
  parameter int   FILT_W      = 4,
  parameter logic RESET_LVL   = 1'b0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [CH-1:0]     async_in,
  input  logic [2*CH-1:0]   mode,
  input  logic [FILT_W-1:0] filt_len,
  input  logic [CH-1:0]     clr,
  output logic [CH-1:0]     pulse_out,
  output logic [CH-1:0]     sticky,
  output logic              any_event
);

  logic [CH-1:0] evt;
  logic [CH-1:0] sticky_q, sticky_d;

  for (genvar g = 0; g < CH; g++) begin : g_chan
    pulse_event_chan #(
      .SYNC_STAGES (SYNC_STAGES),
      .FILT_W      (FILT_W),
      .RESET_LVL   (RESET_LVL)
    ) u_chan (
      .clk        (clk),
      .rst        (rst),
      .async_i    (async_in[g]),
      .mode_i     (mode[2*g+1:2*g]),
      .filt_len_i (filt_len),
      .pulse_o    (pulse_out[g]),
      .evt_o      (evt[g])
    );
  end

  // Set has priority over clear so an event landing on a clear edge is kept.
  assign sticky_d = (sticky_q & ~clr) | evt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sticky_q <= '0;
    end else begin
      sticky_q <= sticky_d;
    end
  end

  assign sticky    = sticky_q;
  assign any_event = |sticky_q;

endmodule

// File: tb/tb_pulse_event_detect.sv
module tb_pulse_event_detect;

  localparam int   CH        = 4;
  localparam int   SYNC      = 2;
  localparam int   FILT_W    = 4;
  localparam logic RESET_LVL = 1'b0;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic [CH-1:0]     async_in = '0;
  logic [2*CH-1:0]   mode = '0;
  logic [FILT_W-1:0] filt_len = '0;
  logic [CH-1:0]     clr = '0;
  logic [CH-1:0]     pulse_out;
  logic [CH-1:0]     sticky;
  logic              any_event;

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model state
  logic [CH-1:0] hist[$];   // input value present at each sampling edge since reset
  logic [CH-1:0] flt_m;
  logic [CH-1:0] pulse_m;
  logic [CH-1:0] sticky_m;

  pulse_event_detect #(
    .CH          (CH),
    .SYNC_STAGES (SYNC),
    .FILT_W      (FILT_W),
    .RESET_LVL   (RESET_LVL)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .async_in  (async_in),
    .mode      (mode),
    .filt_len  (filt_len),
    .clr       (clr),
    .pulse_out (pulse_out),
    .sticky    (sticky),
    .any_event (any_event)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Synchronised level the filter sees at edge j: the pin value SYNC edges
  // earlier, or the reset level before any such sample exists.
  function automatic logic samp(input int ch, input int j);
    logic [CH-1:0] v;
    if (j < SYNC) return RESET_LVL;
    v = hist[j - SYNC];
    return v[ch];
  endfunction

  // A transition commits at edge n when the last F+1 samples all disagree
  // with the committed level.
  task automatic model_edge(input logic [CH-1:0] a, input logic [2*CH-1:0] m,
                            input logic [CH-1:0] c, input logic [FILT_W-1:0] f);
    int  n;
    bit  mis;
    hist.push_back(a);
    n = hist.size() - 1;
    for (int i = 0; i < CH; i++) begin
      mis = 1'b1;
      for (int k = 0; k <= int'(f); k++)
        if (samp(i, n - k) == flt_m[i]) mis = 1'b0;
      pulse_m[i] = 1'b0;
      if (mis) begin
        flt_m[i]   = ~flt_m[i];
        pulse_m[i] = flt_m[i] ? m[2*i] : m[2*i+1];
      end
    end
    sticky_m = (sticky_m & ~c) | pulse_m;
  endtask

  task automatic step(input logic [CH-1:0] a, input logic [2*CH-1:0] m,
                      input logic [CH-1:0] c, input logic [FILT_W-1:0] f);
    async_in = a;
    mode     = m;
    clr      = c;
    filt_len = f;
    @(posedge clk);
    model_edge(a, m, c, f);
    #1;
    chk("pulse_out", 32'(pulse_out), 32'(pulse_m));
    chk("sticky",    32'(sticky),    32'(sticky_m));
    chk("any_event", 32'(any_event), 32'(|sticky_m));
  endtask

  // Reset asserted between edges; outputs must clear without a clock edge.
  task automatic do_reset();
    rst = 1'b1;
    #2;
    chk("rst_pulse",  32'(pulse_out), 32'(0));
    chk("rst_sticky", 32'(sticky),    32'(0));
    chk("rst_any",    32'(any_event), 32'(0));
    @(posedge clk);
    #3;
    rst = 1'b0;
    hist.delete();
    flt_m    = {CH{RESET_LVL}};
    pulse_m  = '0;
    sticky_m = '0;
  endtask

  initial begin
    logic [CH-1:0]     a;
    logic [2*CH-1:0]   m;
    logic [CH-1:0]     c;
    logic [FILT_W-1:0] f;

    #1;
    do_reset();

    // 1: F=0, rise on ch0 -> pulse at edge 2 for one cycle
    step(4'b0001, 8'h55, '0, 4'd0);
    step(4'b0001, 8'h55, '0, 4'd0);
    step(4'b0001, 8'h55, '0, 4'd0);
    chk("t1_pulse", 32'(pulse_out), 32'h1);
    chk("t1_any",   32'(any_event), 32'h1);
    step(4'b0001, 8'h55, '0, 4'd0);
    chk("t1_pulse_gone", 32'(pulse_out), 32'h0);
    chk("t1_sticky",     32'(sticky),    32'h1);

    // 2: F=3, both edges: 3-cycle glitch dropped, 4-cycle high/low reported
    do_reset();
    for (int i = 0; i < 3; i++) step(4'b0001, 8'hFF, '0, 4'd3);
    for (int i = 0; i < 6; i++) step(4'b0000, 8'hFF, '0, 4'd3);
    chk("t2_glitch_sticky", 32'(sticky), 32'h0);
    for (int i = 0; i < 8; i++) step(4'b0001, 8'hFF, '0, 4'd3);
    for (int i = 0; i < 8; i++) step(4'b0000, 8'hFF, '0, 4'd3);

    // 3: ch1 falling only
    do_reset();
    for (int i = 0; i < 4; i++) step(4'b0010, 8'h08, '0, 4'd0);
    chk("t3_no_rise", 32'(sticky), 32'h0);
    for (int i = 0; i < 4; i++) step(4'b0000, 8'h08, '0, 4'd0);
    chk("t3_fall_sticky", 32'(sticky), 32'h2);

    // 4: clear colliding with a ch2 event, then a clean clear
    do_reset();
    step(4'b0100, 8'hFF, '0, 4'd0);
    step(4'b0100, 8'hFF, '0, 4'd0);
    step(4'b0100, 8'hFF, 4'b0100, 4'd0);
    chk("t4_set_wins", 32'(sticky[2]), 32'h1);
    step(4'b0100, 8'hFF, 4'b0100, 4'd0);
    chk("t4_cleared", 32'(sticky),    32'h0);
    chk("t4_any",     32'(any_event), 32'h0);

    // 5: all channels toggle together
    do_reset();
    step(4'hF, 8'hFF, '0, 4'd0);
    step(4'hF, 8'hFF, '0, 4'd0);
    step(4'hF, 8'hFF, '0, 4'd0);
    chk("t5_all", 32'(pulse_out), 32'hF);
    step(4'hF, 8'hFF, '0, 4'd0);
    chk("t5_one_cycle", 32'(pulse_out), 32'h0);
    for (int i = 0; i < 4; i++) step(4'h0, 8'hFF, '0, 4'd0);

    // 6: reset mid-filter (cnt=2, F=5), then one rise SYNC+F edges after release
    do_reset();
    for (int i = 0; i < 4; i++) step(4'b0001, 8'h55, '0, 4'd5);
    do_reset();
    for (int i = 0; i < 7; i++) step(4'b0001, 8'h55, '0, 4'd5);
    chk("t6_not_yet", 32'(sticky), 32'h0);
    step(4'b0001, 8'h55, '0, 4'd5);
    chk("t6_pulse", 32'(pulse_out), 32'h1);
    for (int i = 0; i < 4; i++) step(4'b0001, 8'h55, '0, 4'd5);

    // 7: filter length lowered mid-count commits on the next edge
    do_reset();
    for (int i = 0; i < 6; i++) step(4'b1000, 8'hFF, '0, 4'd12);
    step(4'b1000, 8'hFF, '0, 4'd1);
    chk("t7_lowered", 32'(pulse_out), 32'h8);
    for (int i = 0; i < 3; i++) step(4'b1000, 8'hFF, '0, 4'd1);

    // Randomised phases against the window model
    for (int p = 0; p < 8; p++) begin
      do_reset();
      a = CH'($urandom);
      m = (2*CH)'($urandom);
      f = FILT_W'($urandom_range(0, 4));
      for (int s = 0; s < 250; s++) begin
        for (int i = 0; i < CH; i++)
          if ($urandom_range(0, 5) == 0) a[i] = ~a[i];
        if ($urandom_range(0, 19) == 0) m = (2*CH)'($urandom);
        if ($urandom_range(0, 39) == 0) f = FILT_W'($urandom_range(0, 6));
        c = '0;
        for (int i = 0; i < CH; i++)
          if ($urandom_range(0, 7) == 0) c[i] = 1'b1;
        step(a, m, c, f);
      end
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
